spi_2909_host: RTL and testbench
================================

// Module: spi_2909_host
// PURPOSE
// - Host-side initiator for the SPI_2909 scan-select router; drives its REGSEL/SCLK/SIN pins and samples its SOUT.
// - One transaction = address phase + data phase:
//   - Address phase (REGSEL=1): shift a 5-bit slave index into the router's scan-select register.
//   - Data phase (REGSEL=0): full-duplex shift of DATA_W bits with the selected slave.
// - Sits between the system-side request logic and the router. It generates SCLK from Master_clk.
// PARAMETERS
// - DATA_W   32  data-phase length in bits (>=1)
// - CLK_DIV  2   Master_clk cycles per SCLK half-period (>=1)
// PORTS
// - Master_clk  in   1       system clock; all logic on posedge
// - RESET       in   1       asynchronous, active-low reset
// - start       in   1       request; accepted only in IDLE
// - keep_addr   in   1       sampled with start; 1 = skip address phase, reuse the current router selection
// - addr        in   5       slave index; sampled with start
// - tx_data     in   DATA_W  word to shift out on SIN, MSB first; sampled with start
// - rx_data     out  DATA_W  word captured from SOUT, MSB first; valid from the done cycle until the next accept
// - busy        out  1       high from the cycle after accept through the done cycle
// - done        out  1       1-cycle completion pulse
// - REGSEL      out  1       to router: 1 = address phase, 0 = data phase
// - SCLK        out  1       to router serial clock
// - SIN         out  1       to router serial data
// - SOUT        in   1       from router serial data
// BEHAVIOUR
// - Reset (async, RESET=0): state=IDLE; REGSEL=0, SCLK=0, SIN=0, busy=0, done=0, rx_data=0; divider and bit counters cleared.
// - Tick: divider counts 0..CLK_DIV-1; each wrap is one tick, i.e. one SCLK half-period. Divider runs only outside IDLE.
// - Bit slot = 2 ticks:
//   - Low half: SCLK=0, SIN holds the bit.
//   - High half: SCLK=1.
//   - SOUT is sampled on the Master_clk edge that ends the high half (SCLK 1->0).
// - SIN changes only when SCLK=0. REGSEL changes only when SCLK=0. SCLK never glitches.
// - FSM states and transitions:
//   - IDLE: on start, latch addr/tx_data/keep_addr. Go to ADDR (keep_addr=0) or DATA (keep_addr=1).
//   - ADDR: REGSEL=1; shift addr[4] first, 5 slots. The router latches its decode on the 5th SCLK fall. SOUT ignored. Then go to GAP.
//   - GAP: one slot with REGSEL=0, SCLK=0, SIN=0 (router settling). Then go to DATA.
//   - DATA: REGSEL=0; shift tx_data[DATA_W-1] first; rx shifts left with the SOUT sample. After DATA_W slots go to DONE.
//   - DONE: one cycle; done=1, rx_data updated, SCLK=0, SIN=0. Then go to IDLE.
// - Latency from the accept edge to the done cycle:
//   - Full transaction: (5+1+DATA_W)*2*CLK_DIV + 1 cycles (defaults: 153).
//   - keep_addr=1: DATA_W*2*CLK_DIV + 1 cycles (defaults: 129).
// - start while busy (including the done cycle): ignored, not queued.
// - start in the cycle after done: accepted normally (back-to-back).
// - RESET mid-operation: abort immediately, outputs return to reset values, no done pulse.
//   - RESET is shared with the router, so its selection also clears to slave 0.
//   - keep_addr=1 after reset therefore targets slave 0.
// - Bit counter: $clog2(DATA_W+1) bits, counts down. It reloads with 5 on ADDR entry and DATA_W on DATA entry, with no wrap.
// STRUCTURE
// - Package spi2909_pkg holds:
//   - localparam SPI2909_ADDR_W = 5;
//   - state encodings ST_IDLE, ST_ADDR, ST_GAP, ST_DATA, ST_DONE.
// - Sub-module spi_2909_sclk_gen (CLK_DIV divider):
//   - inputs: Master_clk, RESET, en.
//   - outputs: tick (end of half-period) and phase (current SCLK level).
// - FSM, shift registers and counters live in this module.
// TESTING
// - Bench: DUT + SPI_2909 router + 32 slave models. Each slave is a shift register on S_SCLK[i]: MIN[i] = MSB, MOUT[i] shifted in on the rising edge.
// - addr=3, tx=32'hA5A5_0F0F, slave3 preloaded 32'hDEAD_BEEF, defaults:
//   - S_SCLK[3] pulses 32 times; no other S_SCLK toggles.
//   - slave3 receives A5A5_0F0F.
//   - rx_data=DEAD_BEEF; done at cycle 153.
// - Repeat to addr=3 with keep_addr=1, tx=32'h1234_5678:
//   - no REGSEL=1 cycles; done at cycle 129.
//   - slave3 receives 1234_5678; rx_data=A5A5_0F0F.
// - addr=31, then addr=0, back-to-back (start held high):
//   - second transaction accepted the cycle after done.
//   - only S_SCLK[31], then only S_SCLK[0], toggle.
// - Protocol checkers:
//   - start asserted during busy: no effect, counts unchanged.
//   - REGSEL and SIN edges occur only while SCLK=0 (assertion across all tests).
// - RESET pulsed low in mid-DATA (bit 10):
//   - outputs go to reset values within the reset cycle; no done pulse.
//   - a next transaction with keep_addr=1 reaches slave 0.
// - CLK_DIV=1, DATA_W=8: SCLK = Master_clk/2; done at cycle (5+1+8)*2+1 = 29.

Source files
------------

// File: rtl/spi2909_pkg.sv
// Shared types and constants for the SPI_2909 router host.
package spi2909_pkg;

  localparam int SPI2909_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_DATA,
    ST_DONE
  } spi2909_state_e;

  // The counter also has to reach the 5-slot address length, even when DATA_W is tiny.
  function automatic int spi2909_cnt_w(input int data_w);
    int w;
    w = $clog2(data_w + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/spi_2909_sclk_gen.sv
// SCLK half-period divider: tick marks the last Master_clk cycle of each half-period.
// phase is the SCLK level of the current half and restarts at 0 whenever en drops.
module spi_2909_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic Master_clk,
  input  logic RESET,
  input  logic en,
  output logic tick,
  output logic phase
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;

  assign tick  = en && (div_q == DIV_MAX);
  assign phase = phase_q;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!en) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge Master_clk or negedge RESET) begin
    if (!RESET) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_2909_host.sv
// SPI_2909 host: 5-bit select phase, one-slot gap, DATA_W-bit full-duplex data phase.
// Done after (6+DATA_W)*2*CLK_DIV+1 cycles (DATA_W*2*CLK_DIV+1 with keep_addr); start is ignored while busy.
module spi_2909_host
  import spi2909_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic              Master_clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              keep_addr,
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              REGSEL,
  output logic              SCLK,
  output logic              SIN,
  input  logic              SOUT
);

  localparam int CNT_W = spi2909_cnt_w(DATA_W);

  spi2909_state_e            state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SPI2909_ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0]         tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]         rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]         rx_data_q, rx_data_d;
  logic                      regsel_q, regsel_d;
  logic                      sclk_q, sclk_d;
  logic                      sin_q, sin_d;

  logic              div_en;
  logic              tick;
  logic              phase;
  logic              slot_end;
  logic              sclk_nxt;
  logic [DATA_W-1:0] rx_shifted;

  spi_2909_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .Master_clk(Master_clk),
    .RESET     (RESET),
    .en        (div_en),
    .tick      (tick),
    .phase     (phase)
  );

  assign div_en     = state_q inside {ST_ADDR, ST_GAP, ST_DATA};
  assign slot_end   = tick & phase;
  assign sclk_nxt   = tick ? ~phase : phase;
  assign rx_shifted = DATA_W'({rx_sh_q, SOUT});

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_sh_d = addr_sh_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_sh_d = addr;
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          if (keep_addr) begin
            state_d   = ST_DATA;
            bit_cnt_d = CNT_W'(DATA_W);
          end else begin
            state_d   = ST_ADDR;
            bit_cnt_d = CNT_W'(SPI2909_ADDR_W);
          end
        end
      end
      ST_ADDR: begin
        if (slot_end) begin
          addr_sh_d = addr_sh_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_q == CNT_W'(1)) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (slot_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = CNT_W'(DATA_W);
        end
      end
      ST_DATA: begin
        if (slot_end) begin
          tx_sh_d   = tx_sh_q << 1;
          rx_sh_d   = rx_shifted;
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_q == CNT_W'(1)) begin
            state_d   = ST_DONE;
            rx_data_d = rx_shifted;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered from next state so SCLK/SIN/REGSEL cannot glitch.
    regsel_d = (state_d == ST_ADDR);
    sclk_d   = ((state_d == ST_ADDR) || (state_d == ST_DATA)) && sclk_nxt;
    sin_d    = 1'b0;
    if (state_d == ST_ADDR)      sin_d = addr_sh_d[SPI2909_ADDR_W-1];
    else if (state_d == ST_DATA) sin_d = tx_sh_d[DATA_W-1];
  end

  always_ff @(posedge Master_clk or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      addr_sh_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      regsel_q  <= 1'b0;
      sclk_q    <= 1'b0;
      sin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_sh_q <= addr_sh_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      regsel_q  <= regsel_d;
      sclk_q    <= sclk_d;
      sin_q     <= sin_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign REGSEL  = regsel_q;
  assign SCLK    = sclk_q;
  assign SIN     = sin_q;

endmodule

// File: tb/tb_spi_2909_host.sv
// Host driving a behavioural SPI_2909 router with 32 slaves, plus a CLK_DIV=1/DATA_W=8 host in loopback.
module tb_spi_2909_host;

  logic        Master_clk;
  logic        RESET;
  logic        start, keep_addr;
  logic [4:0]  addr;
  logic [31:0] tx_data, rx_data;
  logic        busy, done, REGSEL, SCLK, SIN, SOUT;

  logic        start_f, keep_f;
  logic [4:0]  addr_f;
  logic [7:0]  tx_f, rx_f;
  logic        busy_f, done_f, regsel_f, sclk_f, sin_f;

  spi_2909_host #(.DATA_W(32), .CLK_DIV(2)) dut (
    .Master_clk(Master_clk), .RESET(RESET), .start(start), .keep_addr(keep_addr),
    .addr(addr), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .REGSEL(REGSEL), .SCLK(SCLK), .SIN(SIN), .SOUT(SOUT)
  );

  spi_2909_host #(.DATA_W(8), .CLK_DIV(1)) dut_f (
    .Master_clk(Master_clk), .RESET(RESET), .start(start_f), .keep_addr(keep_f),
    .addr(addr_f), .tx_data(tx_f), .rx_data(rx_f), .busy(busy_f), .done(done_f),
    .REGSEL(regsel_f), .SCLK(sclk_f), .SIN(sin_f), .SOUT(sin_f)
  );

  initial Master_clk = 1'b0;
  always #5 Master_clk = ~Master_clk;

  // Router + slave model, clocked on Master_clk
  logic [31:0] slv [32];
  logic [31:0] S_SCLK, prv_ssclk;
  logic [4:0]  sel, scan;
  int          fcnt;
  logic        prv_sclk, prv_regsel, prv_sclk_f, pend_bit;
  int          rise_cnt [32];
  int          regsel_cyc, rise_f;
  logic        ld_en, cnt_clr;
  logic [4:0]  ld_idx;
  logic [31:0] ld_val;

  always_comb begin
    S_SCLK = '0;
    if (!REGSEL) S_SCLK[sel] = SCLK;
  end
  assign SOUT = REGSEL ? 1'b0 : slv[sel][31];

  always @(posedge Master_clk or negedge RESET) begin
    if (!RESET) begin
      sel        <= '0;
      scan       <= '0;
      fcnt       <= 0;
      prv_sclk   <= 1'b0;
      prv_regsel <= 1'b0;
      prv_sclk_f <= 1'b0;
      prv_ssclk  <= '0;
    end else begin
      prv_sclk   <= SCLK;
      prv_regsel <= REGSEL;
      prv_sclk_f <= sclk_f;
      prv_ssclk  <= S_SCLK;
      if (REGSEL && SCLK && !prv_sclk) scan <= {scan[3:0], SIN};
      if (!SCLK && prv_sclk && prv_regsel) begin
        if (fcnt == 4) begin
          sel  <= scan;
          fcnt <= 0;
        end else begin
          fcnt <= fcnt + 1;
        end
      end
      if (!REGSEL && SCLK && !prv_sclk) pend_bit <= SIN;
      if (!prv_regsel && !SCLK && prv_sclk) slv[sel] <= {slv[sel][30:0], pend_bit};
      if (ld_en) slv[ld_idx] <= ld_val;
      if (cnt_clr) begin
        for (int i = 0; i < 32; i++) rise_cnt[i] <= 0;
        regsel_cyc <= 0;
        rise_f     <= 0;
      end else begin
        for (int i = 0; i < 32; i++)
          if (S_SCLK[i] && !prv_ssclk[i]) rise_cnt[i] <= rise_cnt[i] + 1;
        if (REGSEL) regsel_cyc <= regsel_cyc + 1;
        if (sclk_f && !prv_sclk_f) rise_f <= rise_f + 1;
      end
    end
  end

  // SIN and REGSEL may only move while SCLK is low
  logic sin_s, rs_s;
  int   edge_chk, edge_bad;
  initial begin
    sin_s = 1'b0; rs_s = 1'b0; edge_chk = 0; edge_bad = 0;
  end
  always @(negedge Master_clk) begin
    sin_s <= SIN;
    rs_s  <= REGSEL;
    if (SIN !== sin_s || REGSEL !== rs_s) begin
      edge_chk <= edge_chk + 1;
      assert (SCLK === 1'b0) else begin
        edge_bad <= edge_bad + 1;
        $error("FAIL edge_vs_sclk: observed SCLK=%b expected 0", SCLK);
      end
    end
  end

  int total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Master_clk);
    #1;
  endtask

  task automatic clr_counts();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  // Counts edges from the accept edge until done is seen (bounded)
  task automatic wait_done(input bit fast, input bit drop, input bit poke, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1 && drop) begin
        start   = 1'b0;
        start_f = 1'b0;
      end
      if (poke && n == 10) begin
        start = 1'b1;
        addr  = 5'd7;
      end
      if (poke && n == 20) start = 1'b0;
    end while (!(fast ? done_f : done) && n < 400);
  endtask

  function automatic int others(input int idx);
    int s = 0;
    for (int i = 0; i < 32; i++) if (i != idx) s += rise_cnt[i];
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    total = 0; bad = 0;
    RESET = 1'b0; start = 1'b0; keep_addr = 1'b0; addr = '0; tx_data = '0;
    start_f = 1'b0; keep_f = 1'b0; addr_f = '0; tx_f = '0;
    ld_en = 1'b0; cnt_clr = 1'b0; ld_idx = '0; ld_val = '0;
    repeat (3) step();

    chk("rst_regsel", REGSEL, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_sin", SIN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_fast_busy", {busy_f, regsel_f}, 0);
    RESET = 1'b1;

    for (int i = 0; i < 32; i++) begin
      ld_en  = 1'b1;
      ld_idx = 5'(i);
      ld_val = (i == 3) ? 32'hDEAD_BEEF : (32'h5A00_0000 | 32'(i));
      step();
    end
    ld_en = 1'b0;
    clr_counts();

    // Full transaction to slave 3, with a start poked mid-transfer
    addr = 5'd3; keep_addr = 1'b0; tx_data = 32'hA5A5_0F0F; start = 1'b1;
    wait_done(0, 1, 1, n);
    chk("t1_latency", n, 153);
    chk("t1_rx", rx_data, 32'hDEAD_BEEF);
    chk("t1_busy_in_done", busy, 1);
    chk("t1_sclk3", rise_cnt[3], 32);
    chk("t1_sclk_others", others(3), 0);
    chk("t1_regsel_cyc", regsel_cyc, 20);
    step();
    chk("t1_idle_busy", {busy, done}, 0);
    chk("t1_rx_hold", rx_data, 32'hDEAD_BEEF);
    chk("t1_slave3", slv[3], 32'hA5A5_0F0F);
    clr_counts();

    // Same slave, address phase skipped
    keep_addr = 1'b1; tx_data = 32'h1234_5678; start = 1'b1;
    wait_done(0, 1, 0, n);
    chk("t2_latency", n, 129);
    chk("t2_rx", rx_data, 32'hA5A5_0F0F);
    chk("t2_regsel_cyc", regsel_cyc, 0);
    chk("t2_sclk3", rise_cnt[3], 32);
    step();
    chk("t2_slave3", slv[3], 32'h1234_5678);
    clr_counts();

    // Back-to-back: slave 31 then slave 0 with start held high
    keep_addr = 1'b0; addr = 5'd31; tx_data = 32'hCAFE_0031; start = 1'b1;
    wait_done(0, 0, 0, n);
    chk("t3a_latency", n, 153);
    chk("t3a_rx", rx_data, 32'h5A00_001F);
    chk("t3a_sclk31", rise_cnt[31], 32);
    chk("t3a_sclk_others", others(31), 0);
    addr = 5'd0; tx_data = 32'h0000_00F0;
    clr_counts();
    chk("t3_idle_gap", busy, 0);
    wait_done(0, 1, 0, n);
    chk("t3b_latency", n, 153);
    chk("t3b_rx", rx_data, 32'h5A00_0000);
    chk("t3b_sclk0", rise_cnt[0], 32);
    chk("t3b_sclk_others", others(0), 0);
    step();
    chk("t3_slave31", slv[31], 32'hCAFE_0031);
    chk("t3_slave0", slv[0], 32'h0000_00F0);

    // Reset during data bit 10 of a transfer to slave 9
    addr = 5'd9; tx_data = 32'hFFFF_0000; start = 1'b1;
    step();
    start = 1'b0;
    repeat (65) step();
    chk("t4_busy_pre", busy, 1);
    chk("t4_sel_pre", sel, 9);
    RESET = 1'b0;
    #1;
    chk("t4_rst_outs", {REGSEL, SCLK, SIN, busy, done}, 0);
    chk("t4_rst_rx", rx_data, 0);
    chk("t4_rst_sel", sel, 0);
    repeat (2) step();
    RESET = 1'b1;
    n = 0;
    repeat (10) begin
      step();
      if (done) n++;
    end
    chk("t4_no_done", n, 0);
    clr_counts();
    keep_addr = 1'b1; tx_data = 32'h0000_FFFF; start = 1'b1;
    wait_done(0, 1, 0, n);
    chk("t4_latency", n, 129);
    chk("t4_rx", rx_data, 32'h0000_00F0);
    chk("t4_sclk0", rise_cnt[0], 32);
    chk("t4_sclk_others", others(0), 0);
    step();
    chk("t4_slave0", slv[0], 32'h0000_FFFF);
    clr_counts();

    // CLK_DIV=1, DATA_W=8, SOUT looped back to SIN
    addr_f = 5'd2; keep_f = 1'b0; tx_f = 8'h3C; start_f = 1'b1;
    wait_done(1, 1, 0, n);
    chk("t5_latency", n, 29);
    chk("t5_rx", rx_f, 8'h3C);
    chk("t5_sclk_pulses", rise_f, 13);
    step();
    keep_f = 1'b1; tx_f = 8'hA7; start_f = 1'b1;
    wait_done(1, 1, 0, n);
    chk("t5k_latency", n, 17);
    chk("t5k_rx", rx_f, 8'hA7);

    step();
    chk("edge_seen", edge_chk > 0, 1);
    chk("edge_bad", edge_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
